led_display_frame_scanner: RTL

- Sits between the frame buffer RAM (written by led_display_pattern_gen) and led_display_driver_phy.
- Reads 64x32 RGB pixels in scan order and splits them into binary-coded-modulation (BCM) bit planes.
- Streams top-half/bottom-half RGB bit pairs to the phy over a valid/ready handshake.
- Sequences row and plane indices, waiting for the phy to finish each row-plane before advancing.

---
 rtl/led_display_pkg.sv | 46 ++++
 rtl/led_display_frame_scanner_if.sv | 21 ++
 rtl/led_display_scan_counter.sv | 67 ++++++
 rtl/led_display_frame_scanner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared types for the LED panel frame scanner:
// FSM states, pixel struct, plane slicing and gamma table.
package led_display_pkg;

  localparam int COLOUR_BITS = 4;
  localparam int PLANE_W     = $clog2(COLOUR_BITS);

  typedef enum logic [2:0] {
    IDLE,
    RD_TOP,
    RD_BOT,
    CAPT,
    PRESENT,
    WAIT_ROW
  } scanner_state_t;

  typedef struct packed {
    logic [COLOUR_BITS-1:0] r;
    logic [COLOUR_BITS-1:0] g;
    logic [COLOUR_BITS-1:0] b;
  } rgb_pixel_t;

  // gamma 2.2, round to nearest; index 0 is the rightmost entry
  localparam logic [15:0][3:0] GAMMA_LUT = {
    4'd15, 4'd13, 4'd11, 4'd9,
    4'd8,  4'd6,  4'd5,  4'd4,
    4'd3,  4'd2,  4'd1,  4'd1,
    4'd0,  4'd0,  4'd0,  4'd0
  };

  function automatic logic [2:0] plane_bits(
    rgb_pixel_t px,
    logic [PLANE_W-1:0] plane
  );
    return {px.r[plane], px.g[plane], px.b[plane]};
  endfunction

  function automatic rgb_pixel_t gamma_px(rgb_pixel_t px);
    rgb_pixel_t o;
    o.r = GAMMA_LUT[px.r];
    o.g = GAMMA_LUT[px.g];
    o.b = GAMMA_LUT[px.b];
    return o;
  endfunction

endpackage

// File: rtl/led_display_frame_scanner_if.sv
// Pixel-pair stream from the frame scanner to the driver phy.
// Valid/ready handshake; payload held while valid && !ready.
interface led_display_frame_scanner_if;

  logic       pix_valid;
  logic       pix_ready;
  logic [2:0] pix_top;
  logic [2:0] pix_bot;
  logic       pix_last;

  modport master (
    output pix_valid, pix_top, pix_bot, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_top, pix_bot, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/led_display_scan_counter.sv
// Nested col / plane / row counters for the frame scanner.
// col steps per pixel; plane then row step per finished row-plane.
module led_display_scan_counter #(
  parameter int NUM_COLS   = 64,
  parameter int NUM_ROWS   = 16,
  parameter int NUM_PLANES = 4,
  localparam int CW = $clog2(NUM_COLS),
  localparam int RW = $clog2(NUM_ROWS),
  localparam int PW = $clog2(NUM_PLANES)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          clear_i,
  input  logic          col_step_i,
  input  logic          rp_step_i,
  output logic [CW-1:0] col_o,
  output logic [PW-1:0] plane_o,
  output logic [RW-1:0] row_o,
  output logic          col_last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, plane_last, row_last;

  assign col_last   = col_q == CW'(NUM_COLS - 1);
  assign plane_last = plane_q == PW'(NUM_PLANES - 1);
  assign row_last   = row_q == RW'(NUM_ROWS - 1);

  always_comb begin
    col_d   = col_q;
    plane_d = plane_q;
    row_d   = row_q;
    if (clear_i) begin
      col_d   = '0;
      plane_d = '0;
      row_d   = '0;
    end else begin
      if (col_step_i)
        col_d = col_last ? '0 : col_q + 1'b1;
      if (rp_step_i) begin
        plane_d = plane_last ? '0 : plane_q + 1'b1;
        if (plane_last)
          row_d = row_last ? '0 : row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      col_q   <= '0;
      plane_q <= '0;
      row_q   <= '0;
    end else begin
      col_q   <= col_d;
      plane_q <= plane_d;
      row_q   <= row_d;
    end
  end

  assign col_o      = col_q;
  assign plane_o    = plane_q;
  assign row_o      = row_q;
  assign col_last_o = col_last;

endmodule

// File: rtl/led_display_frame_scanner.sv
// Frame buffer -> BCM bit-plane pixel-pair streamer for the LED phy.
// Define LED_SCAN_GAMMA_EN to pass channels through the gamma LUT.
module led_display_frame_scanner
  import led_display_pkg::*;
#(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int COLOUR_DEPTH   = COLOUR_BITS,
  localparam int AW = $clog2(NUM_ROW_PIXELS * NUM_COL_PIXELS),
  localparam int RW = $clog2(NUM_ROW_PIXELS / 2),
  localparam int CW = $clog2(NUM_COL_PIXELS),
  localparam int PW = $clog2(COLOUR_DEPTH)
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      enable_in,
  output logic                      fb_rd_en_out,
  output logic [AW-1:0]             fb_addr_out,
  input  logic [3*COLOUR_DEPTH-1:0] fb_data_in,
  led_display_frame_scanner_if.master pix,
  output logic [RW-1:0]             row_addr_out,
  output logic [PW-1:0]             plane_out,
  output logic                      frame_start_out,
  input  logic                      row_done_in,
  output logic                      busy_out
);

  scanner_state_t state_q, state_d;
  rgb_pixel_t     top_q, top_d;
  logic [2:0]     ptop_q, ptop_d, pbot_q, pbot_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           fs_q, fs_d;

  logic          clear, col_step, rp_step, accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;
  logic          col_last;
  logic [AW-1:0] row_ext, col_ext, top_addr, bot_addr;

  function automatic rgb_pixel_t map_px(rgb_pixel_t p);
`ifdef LED_SCAN_GAMMA_EN
    return gamma_px(p);
`else
    return p;
`endif
  endfunction

  led_display_scan_counter #(
    .NUM_COLS   (NUM_COL_PIXELS),
    .NUM_ROWS   (NUM_ROW_PIXELS / 2),
    .NUM_PLANES (COLOUR_DEPTH)
  ) u_cnt (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .clear_i    (clear),
    .col_step_i (col_step),
    .rp_step_i  (rp_step),
    .col_o      (col),
    .plane_o    (plane),
    .row_o      (row),
    .col_last_o (col_last)
  );

  assign row_ext  = AW'(row);
  assign col_ext  = AW'(col);
  assign top_addr = row_ext * AW'(NUM_COL_PIXELS) + col_ext;
  assign bot_addr = (row_ext + AW'(NUM_ROW_PIXELS / 2))
                  * AW'(NUM_COL_PIXELS) + col_ext;

  assign accept = valid_q & pix.pix_ready;

  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    ptop_d   = ptop_q;
    pbot_d   = pbot_q;
    valid_d  = valid_q;
    last_d   = last_q;
    fs_d     = 1'b0;
    clear    = 1'b0;
    col_step = 1'b0;
    rp_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (enable_in) state_d = RD_TOP;
      end
      RD_TOP: state_d = RD_BOT;
      RD_BOT: begin
        top_d   = rgb_pixel_t'(fb_data_in);
        state_d = CAPT;
      end
      CAPT: begin
        ptop_d  = plane_bits(map_px(top_q), plane);
        pbot_d  = plane_bits(
                    map_px(rgb_pixel_t'(fb_data_in)), plane);
        valid_d = 1'b1;
        last_d  = col_last;
        fs_d    = (row == '0) && (plane == '0)
               && (col == '0);
        state_d = PRESENT;
      end
      PRESENT: begin
        if (accept) begin
          valid_d  = 1'b0;
          col_step = 1'b1;
          state_d  = col_last ? WAIT_ROW : RD_TOP;
        end
      end
      WAIT_ROW: begin
        // enable is only honoured at a row-plane boundary
        if (row_done_in) begin
          rp_step = 1'b1;
          state_d = enable_in ? RD_TOP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      top_q   <= '0;
      ptop_q  <= '0;
      pbot_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      ptop_q  <= ptop_d;
      pbot_q  <= pbot_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fs_q    <= fs_d;
    end
  end

  assign fb_rd_en_out = state_q inside {RD_TOP, RD_BOT};
  assign fb_addr_out  = (state_q == RD_TOP) ? top_addr :
                        (state_q == RD_BOT) ? bot_addr : '0;

  assign pix.pix_valid = valid_q;
  assign pix.pix_top   = ptop_q;
  assign pix.pix_bot   = pbot_q;
  assign pix.pix_last  = last_q;

  assign row_addr_out    = row;
  assign plane_out       = plane;
  assign frame_start_out = fs_q;
  assign busy_out        = state_q != IDLE;

endmodule
